// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter in front of the LVT register file.
// Holds the sizing constants, the `LOG2 helper macro and the packed FIFO entry
// type. Everything else in the slice imports this package.
`ifndef LOG2
`define LOG2(x) ($clog2(x))
`endif

package regfile_wb_arbiter_pkg;

  localparam int MEMD    = 16;  // register file depth
  localparam int DATAW   = 32;  // result width
  localparam int NLANES  = 4;   // execution lanes producing writebacks
  localparam int NWPORTS = 2;   // register file write ports, 1..NLANES
  localparam int QDEPTH  = 4;   // per-lane FIFO depth, power of two >= 2

  localparam int ADDRW = `LOG2(MEMD);
  localparam int CNTW  = `LOG2(QDEPTH) + 1;
  localparam int LANEW = (NLANES > 1) ? `LOG2(NLANES) : 1;

  // One queued writeback: destination register and result.
  typedef struct packed {
    logic [ADDRW-1:0] addr;
    logic [DATAW-1:0] data;
  } wb_entry_t;

  localparam int ENTRYW = $bits(wb_entry_t);

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus between the execution lanes / register file and the writeback arbiter.
//   lane_vld/lane_addr/lane_data : per-lane writebacks into the arbiter
//   lane_rdy                     : per-lane FIFO not full
//   WEnb/WAddr/WData             : registered register file write ports
//   idle                         : nothing queued and no write in flight
//   dbg_rr_ptr                   : round-robin scan start, for observation
//
// Handshake: a lane transfers an entry on a rising clk edge where
// lane_vld[i] && lane_rdy[i]. lane_rdy depends only on registered occupancy,
// so it is stable for the whole cycle; lane_vld must not be raised while
// lane_rdy is low. The write ports have no back-pressure: each WEnb bit is one
// register write in that cycle.
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic [NLANES-1:0]        lane_vld;
  logic [ADDRW*NLANES-1:0]  lane_addr;
  logic [DATAW*NLANES-1:0]  lane_data;
  logic [NLANES-1:0]        lane_rdy;
  logic [NWPORTS-1:0]       WEnb;
  logic [ADDRW*NWPORTS-1:0] WAddr;
  logic [DATAW*NWPORTS-1:0] WData;
  logic                     idle;
  logic [LANEW-1:0]         dbg_rr_ptr;

  modport slave (
    input  lane_vld, lane_addr, lane_data,
    output lane_rdy, WEnb, WAddr, WData, idle, dbg_rr_ptr
  );

  modport master (
    output lane_vld, lane_addr, lane_data,
    input  lane_rdy, WEnb, WAddr, WData, idle, dbg_rr_ptr
  );
endinterface

// File: rtl/regfile_wb_arbiter_wb_lane_fifo.sv
// Per-lane writeback FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_din (ignored while o_full)
//   o_full     : count == DEPTH, registered
//   i_pop      : drop the head entry (ignored while o_empty)
//   o_empty    : count == 0, registered
//   o_head     : oldest entry, read from storage (never bypasses a same-cycle push)
//   o_count    : current occupancy
module wb_lane_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  output logic                       o_full,
  input  logic                       i_pop,
  output logic                       o_empty,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTRW-1:0]  r_wptr;
  logic [PTRW-1:0]  r_rptr;
  logic [CNTW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNTW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  // Pointers are exactly PTRW bits wide so they wrap at DEPTH by overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter feeding the multiported LVT register file.
// Results from NLANES lanes are queued per lane; each cycle a round-robin scan
// grants up to NWPORTS heads with pairwise distinct destination registers, pops
// them and registers them onto the write ports.
//   clk   : clock
//   rst_n : asynchronous active-low reset (discards every queued entry)
//   bus   : lane inputs, lane_rdy, WEnb/WAddr/WData, idle, dbg_rr_ptr
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
);

  logic [NLANES-1:0]  w_empty;
  logic [NLANES-1:0]  w_full;
  logic [NLANES-1:0]  w_gnt;
  logic [CNTW-1:0]    w_count [NLANES];
  wb_entry_t          w_head  [NLANES];

  logic [NWPORTS-1:0] w_port_vld;
  logic [ADDRW-1:0]   w_port_addr [NWPORTS];
  logic [DATAW-1:0]   w_port_data [NWPORTS];
  logic               w_any;
  logic [LANEW-1:0]   w_last;
  logic [LANEW-1:0]   w_rr_nxt;
  logic               w_no_entries;

  logic [NWPORTS-1:0]       r_wenb;
  logic [ADDRW*NWPORTS-1:0] r_waddr;
  logic [DATAW*NWPORTS-1:0] r_wdata;
  logic [LANEW-1:0]         r_rr_ptr;

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    wb_lane_fifo #(
      .DEPTH (QDEPTH),
      .WIDTH (ENTRYW)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (bus.lane_vld[i]),
      .i_din   ({bus.lane_addr[i*ADDRW +: ADDRW], bus.lane_data[i*DATAW +: DATAW]}),
      .o_full  (w_full[i]),
      .i_pop   (w_gnt[i]),
      .o_empty (w_empty[i]),
      .o_head  (w_head[i]),
      .o_count (w_count[i])
    );
  end

  assign bus.lane_rdy = ~w_full;

  // Grant scan. Step s visits lane (rr_ptr + s) mod NLANES; the inner lane loop
  // only matches once per step, which keeps every index a loop constant. A lane
  // is granted when it has a head, a port is still free, and its address is
  // not already taken by an earlier grant this cycle. The n-th grant lands on
  // port n.
  always_comb begin : p_scan
    int  n;
    logic hit;
    n          = 0;
    hit        = 1'b0;
    w_gnt      = '0;
    w_port_vld = '0;
    w_any      = 1'b0;
    w_last     = r_rr_ptr;
    for (int k = 0; k < NWPORTS; k++) begin
      w_port_addr[k] = '0;
      w_port_data[k] = '0;
    end
    for (int s = 0; s < NLANES; s++) begin
      for (int l = 0; l < NLANES; l++) begin
        if (l == (int'(r_rr_ptr) + s) % NLANES) begin
          hit = 1'b0;
          for (int k = 0; k < NWPORTS; k++) begin
            if (w_port_vld[k] && (w_port_addr[k] == w_head[l].addr)) hit = 1'b1;
          end
          if (!w_empty[l] && (n < NWPORTS) && !hit) begin
            w_gnt[l] = 1'b1;
            for (int k = 0; k < NWPORTS; k++) begin
              if (k == n) begin
                w_port_vld[k]  = 1'b1;
                w_port_addr[k] = w_head[l].addr;
                w_port_data[k] = w_head[l].data;
              end
            end
            n      = n + 1;
            w_any  = 1'b1;
            w_last = LANEW'(l);
          end
        end
      end
    end
  end

  // Restarting just past the last granted lane is what keeps the scan fair.
  always_comb begin
    w_rr_nxt = r_rr_ptr;
    if (w_any) w_rr_nxt = LANEW'((int'(w_last) + 1) % NLANES);
  end

  always_comb begin
    w_no_entries = 1'b1;
    for (int i = 0; i < NLANES; i++) begin
      if (w_count[i] != '0) w_no_entries = 1'b0;
    end
  end

  // Unused ports keep their last address/data; only the enable drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wenb   <= '0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_wenb   <= w_port_vld;
      r_rr_ptr <= w_rr_nxt;
      for (int k = 0; k < NWPORTS; k++) begin
        if (w_port_vld[k]) begin
          r_waddr[k*ADDRW +: ADDRW] <= w_port_addr[k];
          r_wdata[k*DATAW +: DATAW] <= w_port_data[k];
        end
      end
    end
  end

  assign bus.WEnb       = r_wenb;
  assign bus.WAddr      = r_waddr;
  assign bus.WData      = r_wdata;
  assign bus.idle       = w_no_entries && (r_wenb == '0);
  assign bus.dbg_rr_ptr = r_rr_ptr;

  // A lane must never present a writeback while its FIFO is full; such data
  // would be silently dropped.
  ap_no_push_when_full: assert property (
    @(posedge clk) disable iff (!rst_n) ((bus.lane_vld & ~bus.lane_rdy) == '0)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each lane is a plain queue; every edge the model grants heads in scan order
  // from m_rr, skipping an address already chosen this cycle.
  wb_entry_t                m_q [NLANES][$];
  int                       m_rr = 0;
  logic [NWPORTS-1:0]       exp_wenb = '0;
  logic [ADDRW*NWPORTS-1:0] exp_waddr = '0;
  logic [DATAW*NWPORTS-1:0] exp_wdata = '0;
  logic [ADDRW+DATAW-1:0]   exp_q [$];
  logic [DATAW-1:0]         rf_exp [MEMD];
  logic [DATAW-1:0]         rf_dut [MEMD];

  initial for (int a = 0; a < MEMD; a++) begin
    rf_exp[a] = '0;
    rf_dut[a] = '0;
  end

  function automatic logic [NLANES-1:0] m_rdy_vec();
    logic [NLANES-1:0] r;
    for (int l = 0; l < NLANES; l++) r[l] = (m_q[l].size() < QDEPTH);
    return r;
  endfunction

  function automatic logic m_idle();
    int tot = 0;
    for (int l = 0; l < NLANES; l++) tot += m_q[l].size();
    return (tot == 0) && (exp_wenb == '0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < NLANES; l++) m_q[l].delete();
      m_rr      = 0;
      exp_wenb  = '0;
      exp_waddr = '0;
      exp_wdata = '0;
      exp_q.delete();
    end else begin
      int n;
      int last;
      bit busy;
      logic [ADDRW-1:0]  ga [NWPORTS];
      logic [NLANES-1:0] pre_rdy;
      logic [NLANES-1:0] gl;
      wb_entry_t hd;
      n = 0; last = -1; gl = '0; exp_wenb = '0;
      pre_rdy = m_rdy_vec();
      for (int s = 0; s < NLANES; s++) begin
        int l;
        l = (m_rr + s) % NLANES;
        if (m_q[l].size() > 0 && n < NWPORTS) begin
          hd = m_q[l][0];
          busy = 1'b0;
          for (int j = 0; j < n; j++) if (ga[j] == hd.addr) busy = 1'b1;
          if (!busy) begin
            ga[n] = hd.addr;
            exp_wenb[n] = 1'b1;
            exp_waddr[n*ADDRW +: ADDRW] = hd.addr;
            exp_wdata[n*DATAW +: DATAW] = hd.data;
            exp_q.push_back(hd);
            rf_exp[hd.addr] = hd.data;
            gl[l] = 1'b1;
            n++;
            last = l;
          end
        end
      end
      for (int l = 0; l < NLANES; l++) if (gl[l]) void'(m_q[l].pop_front());
      for (int l = 0; l < NLANES; l++)
        if (bus.lane_vld[l] && pre_rdy[l])
          m_q[l].push_back({bus.lane_addr[l*ADDRW +: ADDRW], bus.lane_data[l*DATAW +: DATAW]});
      if (last >= 0) m_rr = (last + 1) % NLANES;
    end
  end

  // ---------------- compare process + scoreboard ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("wenb", 64'(bus.WEnb), 64'(exp_wenb));
      chk("waddr", 64'(bus.WAddr), 64'(exp_waddr));
      chk("wdata", 64'(bus.WData), 64'(exp_wdata));
      chk("lane_rdy", 64'(bus.lane_rdy), 64'(m_rdy_vec()));
      chk("idle", 64'(bus.idle), 64'(m_idle()));
      chk("rr_ptr", 64'(bus.dbg_rr_ptr), 64'(m_rr));
      for (int j = 0; j < NWPORTS; j++)
        for (int k = j + 1; k < NWPORTS; k++)
          if (bus.WEnb[j] && bus.WEnb[k])
            chk("addr_distinct", 64'(bus.WAddr[j*ADDRW +: ADDRW] == bus.WAddr[k*ADDRW +: ADDRW]), 64'(0));
      for (int k = 0; k < NWPORTS; k++) begin
        if (bus.WEnb[k]) begin
          logic [ADDRW-1:0] a;
          logic [DATAW-1:0] d;
          a = bus.WAddr[k*ADDRW +: ADDRW];
          d = bus.WData[k*DATAW +: DATAW];
          rf_dut[a] = d;
          if (exp_q.size() == 0) chk("sb_unexpected_write", 64'({a, d}), 64'(0));
          else chk("sb_write", 64'({a, d}), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [ADDRW-1:0] t_addr [NLANES];
  logic [DATAW-1:0] t_data [NLANES];

  // Valid is masked with the model's ready so no push is ever attempted on a full lane.
  task automatic apply(input logic [NLANES-1:0] v);
    for (int l = 0; l < NLANES; l++) begin
      bus.lane_addr[l*ADDRW +: ADDRW] = t_addr[l];
      bus.lane_data[l*DATAW +: DATAW] = t_data[l];
    end
    bus.lane_vld = v & m_rdy_vec();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic drain(input string nm);
    int c = 0;
    bus.lane_vld = '0;
    while (!bus.idle && c < 64) begin
      @(negedge clk);
      c++;
    end
    chk(nm, 64'(bus.idle), 64'(1));
  endtask

  // ---------------- stimulus ----------------
  bit fill_seen;

  initial begin
    rst_n = 1'b0;
    bus.lane_vld = '0;
    bus.lane_addr = '0;
    bus.lane_data = '0;
    for (int l = 0; l < NLANES; l++) begin
      t_addr[l] = '0;
      t_data[l] = '0;
    end
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_wenb", 64'(bus.WEnb), 64'(0));
    chk("rst_waddr", 64'(bus.WAddr), 64'(0));
    chk("rst_wdata", 64'(bus.WData), 64'(0));
    chk("rst_rdy", 64'(bus.lane_rdy), 64'hF);
    chk("rst_idle", 64'(bus.idle), 64'(1));
    #2 rst_n = 1'b1;

    // single write latency
    t_addr[0] = 4'd3; t_data[0] = 32'hA5A5A5A5;
    apply(4'b0001);
    @(negedge clk); apply(4'b0000);
    @(negedge clk);
    chk("t1_wenb", 64'(bus.WEnb), 64'b01);
    chk("t1_waddr", 64'(bus.WAddr[3:0]), 64'd3);
    chk("t1_wdata", 64'(bus.WData[31:0]), 64'hA5A5A5A5);
    @(negedge clk);
    chk("t1_idle", 64'(bus.idle), 64'(1));
    chk("t1_wenb_off", 64'(bus.WEnb), 64'(0));

    // four distinct addresses at once
    do_reset();
    for (int l = 0; l < NLANES; l++) begin
      t_addr[l] = ADDRW'(l + 1);
      t_data[l] = 32'h100 + l;
    end
    apply(4'b1111);
    @(negedge clk); apply(4'b0000);
    @(negedge clk);
    chk("t2_c2_wenb", 64'(bus.WEnb), 64'b11);
    chk("t2_c2_waddr", 64'(bus.WAddr), 64'h21);
    chk("t2_c2_wdata", 64'(bus.WData), 64'h00000101_00000100);
    @(negedge clk);
    chk("t2_c3_wenb", 64'(bus.WEnb), 64'b11);
    chk("t2_c3_waddr", 64'(bus.WAddr), 64'h43);
    chk("t2_c3_wdata", 64'(bus.WData), 64'h00000103_00000102);
    chk("t2_rr", 64'(bus.dbg_rr_ptr), 64'(0));

    // same-address conflict
    do_reset();
    t_addr[0] = 4'd5; t_data[0] = 32'h11;
    t_addr[1] = 4'd5; t_data[1] = 32'h22;
    apply(4'b0011);
    @(negedge clk); apply(4'b0000);
    @(negedge clk);
    chk("t3_c2_wenb", 64'(bus.WEnb), 64'b01);
    chk("t3_c2_waddr", 64'(bus.WAddr[3:0]), 64'd5);
    chk("t3_c2_wdata", 64'(bus.WData[31:0]), 64'h11);
    @(negedge clk);
    chk("t3_c3_wenb", 64'(bus.WEnb), 64'b01);
    chk("t3_c3_waddr", 64'(bus.WAddr[3:0]), 64'd5);
    chk("t3_c3_wdata", 64'(bus.WData[31:0]), 64'h22);
    @(negedge clk);
    chk("t3_idle", 64'(bus.idle), 64'(1));

    // fill lane 2: every lane targets the same register, so one write per cycle
    do_reset();
    fill_seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      for (int l = 0; l < NLANES; l++) begin
        t_addr[l] = 4'd7;
        t_data[l] = 32'(c * 16 + l);
      end
      apply(4'b1111);
      @(negedge clk);
      if (!bus.lane_rdy[2]) fill_seen = 1'b1;
    end
    chk("t4_rdy2_low", 64'(fill_seen), 64'(1));
    drain("t4_drain");

    // random traffic
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      logic [NLANES-1:0] v;
      int amax;
      amax = ((c / 1000) % 2 == 0) ? 3 : MEMD - 1;
      for (int l = 0; l < NLANES; l++) begin
        t_addr[l] = ADDRW'($urandom_range(0, amax));
        t_data[l] = $urandom;
        v[l] = ($urandom_range(0, 99) < 55);
      end
      apply(v);
      @(negedge clk);
    end
    drain("t5_drain");
    chk("t5_sb_empty", 64'(exp_q.size()), 64'(0));
    for (int a = 0; a < MEMD; a++) chk("t5_regfile", 64'(rf_dut[a]), 64'(rf_exp[a]));

    // reset with entries queued
    for (int l = 0; l < NLANES; l++) begin
      t_addr[l] = 4'd9;
      t_data[l] = 32'h900 + l;
    end
    apply(4'b1111);
    @(negedge clk); apply(4'b0000);
    @(negedge clk);
    chk("t6_pre_wenb", 64'(bus.WEnb), 64'b01);
    chk("t6_pre_rdy", 64'(bus.lane_rdy), 64'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_wenb", 64'(bus.WEnb), 64'(0));
    chk("t6_rst_rdy", 64'(bus.lane_rdy), 64'hF);
    chk("t6_rst_idle", 64'(bus.idle), 64'(1));
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t6_quiet_wenb", 64'(bus.WEnb), 64'(0));
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
